diag_spi_controller: RTL and testbench

- SPI-slave diagnostics controller inside the ROMulator FPGA, active once the flash image load is complete.
- A host halts the 8-bit CPU, then reads or writes the 64 KB shadow RAM through a dedicated RAM port.
- Also reads the dual-port video RAM, and holds the memory-configuration select and the RAM/ROM disable flags used by the enable logic.

---
 rtl/diag_spi_controller_pkg.sv | 24 ++
 rtl/diag_spi_controller_if.sv | 29 ++
 rtl/diag_spi_shifter.sv | 77 +++++++
 rtl/diag_spi_controller.sv | 197 +++++++++++++++++++
 tb/tb_diag_spi_controller.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/diag_spi_controller_pkg.sv
// Shared definitions for the ROMulator SPI diagnostics controller.
// Holds the command opcodes, the default configuration-select width and
// the byte-level FSM state encoding.
package diag_spi_controller_pkg;

  localparam int CONFIG_BITS = 5;

  localparam logic [7:0] CMD_HALT       = 8'h01;
  localparam logic [7:0] CMD_RUN        = 8'h02;
  localparam logic [7:0] CMD_READ_MEM   = 8'h03;
  localparam logic [7:0] CMD_WRITE_MEM  = 8'h04;
  localparam logic [7:0] CMD_SET_CONFIG = 8'h05;
  localparam logic [7:0] CMD_READ_VRAM  = 8'h06;
  localparam logic [7:0] CMD_STATUS     = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA
  } state_e;

endpackage

// File: rtl/diag_spi_controller_if.sv
// SPI pins and shadow-RAM port of the diagnostics controller.
//   spi_cs_n/spi_clk/spi_mosi : host -> controller (asynchronous to clk)
//   spi_miso                  : controller -> host
//   ram_addr/ram_wdata/ram_we/ram_cs : controller -> RAM
//   ram_rdata                 : RAM -> controller, valid 1 clk after ram_cs
// Modport master is the controller side, slave is the host/RAM side.
interface diag_spi_controller_if #(
  parameter int ADDR_W = 16
);
  logic              spi_cs_n;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic              ram_cs;

  modport master (
    input  spi_cs_n, spi_clk, spi_mosi, ram_rdata,
    output spi_miso, ram_addr, ram_wdata, ram_we, ram_cs
  );

  modport slave (
    output spi_cs_n, spi_clk, spi_mosi, ram_rdata,
    input  spi_miso, ram_addr, ram_wdata, ram_we, ram_cs
  );
endinterface

// File: rtl/diag_spi_shifter.sv
// SPI mode-0 bit layer: synchronises the host pins into clk, detects edges,
// assembles received bytes MSB first and shifts tx_byte out on MISO.
//   cs_fall/cs_rise : one-clk strobes on synchronised chip-select edges
//   byte_done       : one-clk strobe on the 8th SCK rising edge, rx_byte valid
//   tx_byte         : byte to send, sampled on the SCK falling edge that
//                     follows the previous byte's 8th rising edge
module diag_spi_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte,
  output logic       spi_miso,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte
);
  logic       sck_p0, sck_p1, sck_p2;
  logic       cs_p0, cs_p1, cs_p2;
  logic       mosi_p0, mosi_p1;
  logic       sck_rise, sck_fall;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr;

  // sync stage p0/p1, p2 only for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_p0 <= 1'b0; sck_p1 <= 1'b0; sck_p2 <= 1'b0;
      cs_p0 <= 1'b1; cs_p1 <= 1'b1; cs_p2 <= 1'b1;
      mosi_p0 <= 1'b0; mosi_p1 <= 1'b0;
    end else begin
      sck_p0 <= spi_clk;  sck_p1 <= sck_p0; sck_p2 <= sck_p1;
      cs_p0 <= spi_cs_n;  cs_p1 <= cs_p0;   cs_p2 <= cs_p1;
      mosi_p0 <= spi_mosi; mosi_p1 <= mosi_p0;
    end
  end

  assign sck_rise  = sck_p1 & ~sck_p2;
  assign sck_fall  = ~sck_p1 & sck_p2;
  assign cs_fall   = ~cs_p1 & cs_p2;
  assign cs_rise   = cs_p1 & ~cs_p2;
  assign rx_byte   = {rx_sr[6:0], mosi_p1};
  assign byte_done = ~cs_p1 & sck_rise & (bit_cnt == 3'd7);

  // shift stage: CS high holds everything cleared, so a partial byte is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_sr    <= 8'h00;
      tx_sr    <= 8'h00;
      spi_miso <= 1'b0;
    end else if (cs_p1) begin
      bit_cnt  <= 3'd0;
      rx_sr    <= 8'h00;
      tx_sr    <= 8'h00;
      spi_miso <= 1'b0;
    end else begin
      if (sck_rise) begin
        rx_sr   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      // bit_cnt==0 on a falling edge means a byte just finished: present
      // bit 7 of the next byte before the host's next rising edge
      if (sck_fall) begin
        if (bit_cnt == 3'd0) begin
          spi_miso <= tx_byte[7];
          tx_sr    <= {tx_byte[6:0], 1'b0};
        end else begin
          spi_miso <= tx_sr[7];
          tx_sr    <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: rtl/diag_spi_controller.sv
// SPI-slave diagnostics controller: halts the CPU, reads/writes the shadow
// RAM, streams VRAM and holds the memory configuration flags.
// Ports: clk, rst (async, active high); halt; bus (SPI pins + RAM port,
// master modport); configuration/ram_disable_in/rom_disable_in straps;
// config_byte/ram_disable_out/rom_disable_out active flags; vram_raddr,
// vram_rdata, vram_rclk, vram_size for the VRAM read port.
// Build option: define DIAG_VRAM_READ_EN to enable command 0x06 (READ_VRAM);
// otherwise vram_raddr is tied to 0 and 0x06 is an unknown command.
module diag_spi_controller #(
  parameter int CONFIG_BITS = diag_spi_controller_pkg::CONFIG_BITS,
  parameter int ADDR_W      = 16,
  parameter int VRAM_AW     = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   halt,
  diag_spi_controller_if.master  bus,
  input  logic [CONFIG_BITS-1:0] configuration,
  output logic [VRAM_AW-1:0]     vram_raddr,
  input  logic [7:0]             vram_rdata,
  output logic                   vram_rclk,
  output logic [CONFIG_BITS-1:0] config_byte,
  input  logic [VRAM_AW-1:0]     vram_size,
  input  logic                   ram_disable_in,
  output logic                   ram_disable_out,
  input  logic                   rom_disable_in,
  output logic                   rom_disable_out
);
  import diag_spi_controller_pkg::*;

`ifdef DIAG_VRAM_READ_EN
  localparam bit VRAM_EN = 1'b1;
`else
  localparam bit VRAM_EN = 1'b0;
`endif

  state_e                 state;
  logic [7:0]             cmd_q, addr_hi_q, tx_byte, rx_byte, status;
  logic [ADDR_W-1:0]      addr_q, addr_start, ram_addr_q;
  logic [7:0]             ram_wdata_q;
  logic                   ram_cs_q, ram_we_q;
  logic [VRAM_AW-1:0]     vram_raddr_q;
  logic [VRAM_AW:0]       vram_next;
  logic                   vram_wrap;
  logic                   rd_p0, rd_p1, vrd_p0, vrd_p1;
  logic                   loaded_q, halt_q, ram_dis_q, rom_dis_q;
  logic [CONFIG_BITS-1:0] config_q;
  logic                   cs_fall, cs_rise, byte_done, miso;

  diag_spi_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .spi_cs_n  (bus.spi_cs_n),
    .spi_clk   (bus.spi_clk),
    .spi_mosi  (bus.spi_mosi),
    .tx_byte   (tx_byte),
    .spi_miso  (miso),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  assign bus.spi_miso    = miso;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_we      = ram_we_q;
  assign halt            = halt_q;
  assign config_byte     = config_q;
  assign ram_disable_out = ram_dis_q;
  assign rom_disable_out = rom_dis_q;
  assign vram_rclk       = clk;
  assign vram_raddr      = VRAM_EN ? vram_raddr_q : '0;

  assign addr_start = ADDR_W'({addr_hi_q, rx_byte});
  assign vram_next  = {1'b0, vram_raddr_q} + (VRAM_AW + 1)'(1);
  assign vram_wrap  = vram_next >= {1'b0, vram_size};
  assign status     = 8'({halt_q, rom_dis_q, ram_dis_q, config_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_q        <= 8'h00;
      addr_hi_q    <= 8'h00;
      addr_q       <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 8'h00;
      ram_cs_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      vram_raddr_q <= '0;
      tx_byte      <= 8'h00;
      rd_p0        <= 1'b0;
      rd_p1        <= 1'b0;
      vrd_p0       <= 1'b0;
      vrd_p1       <= 1'b0;
      loaded_q     <= 1'b0;
      halt_q       <= 1'b0;
      config_q     <= '0;
      ram_dis_q    <= 1'b0;
      rom_dis_q    <= 1'b0;
    end else begin
      ram_cs_q <= 1'b0;
      ram_we_q <= 1'b0;
      rd_p0    <= 1'b0;
      vrd_p0   <= 1'b0;
      rd_p1    <= rd_p0;
      vrd_p1   <= vrd_p0;

      if (!loaded_q) begin
        loaded_q  <= 1'b1;
        config_q  <= configuration;
        ram_dis_q <= ram_disable_in;
        rom_dis_q <= rom_disable_in;
      end

      // fetch stage: memory data arrives 1 clk after the request cycle
      if (rd_p1)  tx_byte <= bus.ram_rdata;
      if (vrd_p1) tx_byte <= vram_rdata;

      if (cs_rise) begin
        state <= ST_IDLE;
      end else if (cs_fall) begin
        state   <= ST_CMD;
        tx_byte <= 8'h00;
      end else if (byte_done) begin
        case (state)
          ST_CMD: begin
            cmd_q   <= rx_byte;
            tx_byte <= 8'h00;
            state   <= ST_DATA;
            case (rx_byte)
              CMD_HALT:      halt_q <= 1'b1;
              CMD_RUN:       halt_q <= 1'b0;
              CMD_READ_MEM,
              CMD_WRITE_MEM: state <= ST_ADDR_HI;
              CMD_STATUS:    tx_byte <= status;
              CMD_READ_VRAM: begin
                vram_raddr_q <= '0;
                vrd_p0       <= VRAM_EN && (vram_size != '0);
              end
              default: ;
            endcase
          end
          ST_ADDR_HI: begin
            addr_hi_q <= rx_byte;
            state     <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            state <= ST_DATA;
            if (cmd_q == CMD_READ_MEM) begin
              ram_addr_q <= addr_start;
              ram_cs_q   <= halt_q;
              rd_p0      <= halt_q;
              addr_q     <= addr_start + ADDR_W'(1);
            end else begin
              addr_q <= addr_start;
            end
          end
          ST_DATA: begin
            case (cmd_q)
              CMD_READ_MEM: begin
                ram_addr_q <= addr_q;
                ram_cs_q   <= halt_q;
                rd_p0      <= halt_q;
                if (!halt_q) tx_byte <= 8'h00;
                addr_q     <= addr_q + ADDR_W'(1);
              end
              CMD_WRITE_MEM: begin
                if (halt_q) begin
                  ram_addr_q  <= addr_q;
                  ram_wdata_q <= rx_byte;
                  ram_cs_q    <= 1'b1;
                  ram_we_q    <= 1'b1;
                end
                addr_q <= addr_q + ADDR_W'(1);
              end
              CMD_SET_CONFIG: begin
                config_q  <= rx_byte[CONFIG_BITS-1:0];
                ram_dis_q <= rx_byte[5];
                rom_dis_q <= rx_byte[6];
                cmd_q     <= 8'h00;
              end
              CMD_READ_VRAM: begin
                vram_raddr_q <= vram_wrap ? '0 : vram_next[VRAM_AW-1:0];
                vrd_p0       <= VRAM_EN && (vram_size != '0);
                tx_byte      <= 8'h00;
              end
              default: tx_byte <= 8'h00;
            endcase
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_diag_spi_controller.sv
module tb_diag_spi_controller;
  import diag_spi_controller_pkg::*;

  localparam int HALF = 10;

  typedef struct {
    bit         chk;
    logic [7:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [4:0]  configuration;
  logic [10:0] vram_raddr;
  logic [7:0]  vram_rdata;
  logic        vram_rclk;
  logic [4:0]  config_byte;
  logic [10:0] vram_size;
  logic        ram_disable_in, ram_disable_out;
  logic        rom_disable_in, rom_disable_out;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_base;

  logic [7:0] mem  [0:65535];
  logic [7:0] vram [0:2047];
  logic [7:0] tx_q [$];
  exp_t       exp_q[$];

  always #5 clk = ~clk;

  diag_spi_controller_if #(.ADDR_W(16)) bus();

  diag_spi_controller dut (
    .clk             (clk),
    .rst             (rst),
    .halt            (halt),
    .bus             (bus.master),
    .configuration   (configuration),
    .vram_raddr      (vram_raddr),
    .vram_rdata      (vram_rdata),
    .vram_rclk       (vram_rclk),
    .config_byte     (config_byte),
    .vram_size       (vram_size),
    .ram_disable_in  (ram_disable_in),
    .ram_disable_out (ram_disable_out),
    .rom_disable_in  (rom_disable_in),
    .rom_disable_out (rom_disable_out)
  );

  // shadow RAM and VRAM models, both with 1-clk read latency
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      wr_count          <= wr_count + 1;
    end
    if (bus.ram_cs) bus.ram_rdata <= mem[bus.ram_addr];
    vram_rdata <= vram[vram_raddr];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit chk, input logic [7:0] val);
    exp_t e;
    e.chk = chk;
    e.val = val;
    tx_q.push_back(b);
    exp_q.push_back(e);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
  endtask

  // sends the queued bytes in one CS frame; partial_bits>0 appends a cut byte
  task automatic txn(input string tag, input int partial_bits);
    logic [7:0] b, r;
    exp_t       e;
    int         idx;
    idx = 0;
    bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      e = exp_q.pop_front();
      spi_byte(b, 8, r);
      if (e.chk) check($sformatf("%s[%0d]", tag, idx), {8'h00, r}, {8'h00, e.val});
      idx++;
    end
    if (partial_bits > 0) spi_byte(8'hFF, partial_bits, r);
    repeat (HALF) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    bus.spi_cs_n   = 1'b1;
    bus.spi_clk    = 1'b0;
    bus.spi_mosi   = 1'b0;
    configuration  = 5'h13;
    ram_disable_in = 1'b1;
    rom_disable_in = 1'b0;
    vram_size      = 11'd3;
    for (int i = 0; i < 2048; i++) vram[i] = 8'hEE;
    vram[0] = 8'h11; vram[1] = 8'h22; vram[2] = 8'h33;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_halt", {15'd0, halt}, 16'd0);
    check("rst_ram_cs", {15'd0, bus.ram_cs}, 16'd0);
    check("rst_ram_addr", bus.ram_addr, 16'h0000);
    check("rst_miso", {15'd0, bus.spi_miso}, 16'd0);
    check("rst_config", {11'd0, config_byte}, 16'd0);
    check("rst_ram_dis", {15'd0, ram_disable_out}, 16'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("load_config", {11'd0, config_byte}, 16'h0013);
    check("load_ram_dis", {15'd0, ram_disable_out}, 16'd1);
    check("load_rom_dis", {15'd0, rom_disable_out}, 16'd0);

    push(CMD_STATUS, 1, 8'h00); push(8'h00, 1, 8'h33);
    txn("status0", 0);
    check("halt_idle", {15'd0, halt}, 16'd0);

    push(CMD_HALT, 1, 8'h00);
    txn("halt_cmd", 0);
    check("halt_set", {15'd0, halt}, 16'd1);

    wr_base = wr_count;
    push(CMD_WRITE_MEM, 1, 8'h00); push(8'h12, 1, 8'h00); push(8'h34, 1, 8'h00);
    push(8'hAA, 0, 8'h00); push(8'hBB, 0, 8'h00);
    txn("write", 0);
    check("mem_1234", {8'h00, mem[16'h1234]}, 16'h00AA);
    check("mem_1235", {8'h00, mem[16'h1235]}, 16'h00BB);
    check("write_strobes", 16'(wr_count - wr_base), 16'd2);

    push(CMD_READ_MEM, 1, 8'h00); push(8'h12, 1, 8'h00); push(8'h34, 1, 8'h00);
    push(8'h00, 1, 8'hAA); push(8'h00, 1, 8'hBB);
    txn("read", 0);

    push(CMD_WRITE_MEM, 0, 8'h00); push(8'hFF, 0, 8'h00); push(8'hFF, 0, 8'h00);
    push(8'h5A, 0, 8'h00); push(8'hA5, 0, 8'h00);
    txn("write_wrap", 0);
    check("mem_0000", {8'h00, mem[16'h0000]}, 16'h00A5);
    push(CMD_READ_MEM, 0, 8'h00); push(8'hFF, 0, 8'h00); push(8'hFF, 0, 8'h00);
    push(8'h00, 1, 8'h5A); push(8'h00, 1, 8'hA5);
    txn("read_wrap", 0);

    push(CMD_SET_CONFIG, 1, 8'h00); push(8'h45, 1, 8'h00);
    txn("set_config", 0);
    check("cfg_byte", {11'd0, config_byte}, 16'h0005);
    check("cfg_ram_dis", {15'd0, ram_disable_out}, 16'd0);
    check("cfg_rom_dis", {15'd0, rom_disable_out}, 16'd1);
    push(CMD_STATUS, 0, 8'h00); push(8'h00, 1, 8'hC5);
    txn("status1", 0);

    push(CMD_READ_VRAM, 1, 8'h00);
`ifdef DIAG_VRAM_READ_EN
    push(8'h00, 1, 8'h11); push(8'h00, 1, 8'h22); push(8'h00, 1, 8'h33); push(8'h00, 1, 8'h11);
`else
    push(8'h00, 1, 8'h00); push(8'h00, 1, 8'h00); push(8'h00, 1, 8'h00); push(8'h00, 1, 8'h00);
`endif
    txn("vram", 0);

    push(CMD_WRITE_MEM, 0, 8'h00); push(8'h00, 0, 8'h00); push(8'h10, 0, 8'h00);
    push(8'h77, 0, 8'h00);
    txn("write_0010", 0);
    wr_base = wr_count;
    push(CMD_WRITE_MEM, 0, 8'h00); push(8'h00, 0, 8'h00); push(8'h10, 0, 8'h00);
    txn("partial", 4);
    check("partial_no_write", 16'(wr_count - wr_base), 16'd0);
    check("partial_mem", {8'h00, mem[16'h0010]}, 16'h0077);

    push(CMD_RUN, 1, 8'h00);
    txn("run_cmd", 0);
    check("halt_clr", {15'd0, halt}, 16'd0);
    wr_base = wr_count;
    push(CMD_WRITE_MEM, 0, 8'h00); push(8'h00, 0, 8'h00); push(8'h10, 0, 8'h00);
    push(8'h55, 0, 8'h00);
    txn("run_write", 0);
    check("run_no_write", 16'(wr_count - wr_base), 16'd0);
    push(CMD_READ_MEM, 0, 8'h00); push(8'h00, 0, 8'h00); push(8'h10, 0, 8'h00);
    push(8'h00, 1, 8'h00);
    txn("run_read", 0);

    push(CMD_HALT, 0, 8'h00);
    txn("halt_again", 0);
    push(CMD_READ_MEM, 0, 8'h00); push(8'h00, 0, 8'h00); push(8'h10, 0, 8'h00);
    push(8'h00, 1, 8'h77);
    txn("readback_0010", 0);

    push(8'h9C, 1, 8'h00); push(8'h00, 1, 8'h00);
    txn("unknown_cmd", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
